// File: rtl/iq_ctrl.sv
// Inquiry substate controller: TX/RX slot alternation, A/B train selection,
// inquiry-length timeout and response-count limit. Optional macro: IQ_SCO_TRAIN_EN.
module iq_ctrl #(
    parameter int TRAIN_SLOTS = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             tslot_p,
    input  logic             regi_InquiryEnable,
    input  logic [CNT_W-1:0] regi_Tinquirylength,
    input  logic [9:0]       regi_Ntrain,
    input  logic [7:0]       regi_Nresp,
    input  logic [2:0]       regi_Tsco,
    input  logic [1:0]       regi_scolink_num,
    input  logic             fhs_rcvd,
    output logic             iq_active,
    output logic             iq_tx_slot,
    output logic             iq_rx_slot,
    output logic             iq_train,
    output logic [4:0]       iq_koffset,
    output logic [7:0]       iq_resp_cnt,
    output logic             iq_done,
    output logic             iq_timeout
);

    localparam logic [4:0] KOFF_A = 5'd24;
    localparam logic [4:0] KOFF_B = 5'd8;

    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] slot_q, rep_q, tout_q;
    logic [7:0]       resp_q;
    logic             train_q, active_q, tx_q, rx_q, done_q, tmo_q;
    logic [4:0]       koff_q;

    logic [CNT_W-1:0] tinq_eff, tout_d, rep_lim;
    logic [9:0]       ntrain_base;
    logic [11:0]      ntrain_eff;
    logic [7:0]       resp_d;
    logic             hit_resp, hit_tout, wrap, go_idle;

    always_comb begin
        tinq_eff    = (regi_Tinquirylength == '0) ? CNT_W'(1) : regi_Tinquirylength;
        ntrain_base = (regi_Ntrain == 10'd0) ? 10'd1 : regi_Ntrain;
        tout_d      = tout_q + CNT_W'(tslot_p);
        resp_d      = resp_q;
        // Responses only count while listening; the counter sticks at 255.
        if (state_q == S_RX && fhs_rcvd && resp_q != 8'hFF)
            resp_d = resp_q + 8'd1;
        hit_resp = (regi_Nresp != 8'd0) && (resp_d >= regi_Nresp);
        hit_tout = (tout_d >= tinq_eff);
        wrap     = (slot_q == CNT_W'(TRAIN_SLOTS - 1));
        go_idle  = (state_q != S_IDLE) && !regi_InquiryEnable;
    end

`ifdef IQ_SCO_TRAIN_EN
    logic [1:0] sco_mult;
    always_comb begin
        sco_mult = 2'd1;
        if (regi_Tsco == 3'd6) begin
            case (regi_scolink_num)
                2'd0:    sco_mult = 2'd1;
                2'd1:    sco_mult = 2'd2;
                default: sco_mult = 2'd3;
            endcase
        end
    end
    assign ntrain_eff = {2'b00, ntrain_base} * {10'd0, sco_mult};
`else
    logic unused_sco;
    assign unused_sco = ^{regi_Tsco, regi_scolink_num};
    assign ntrain_eff = {2'b00, ntrain_base};
`endif

    assign rep_lim = CNT_W'(ntrain_eff - 12'd1);

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            rep_q    <= '0;
            tout_q   <= '0;
            resp_q   <= '0;
            train_q  <= 1'b0;
            koff_q   <= KOFF_A;
            active_q <= 1'b0;
            tx_q     <= 1'b0;
            rx_q     <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            if (go_idle) begin
                // Abort or release from DONE: back to a reset-like idle, no pulses.
                state_q  <= S_IDLE;
                slot_q   <= '0;
                rep_q    <= '0;
                tout_q   <= '0;
                resp_q   <= '0;
                train_q  <= 1'b0;
                koff_q   <= KOFF_A;
                active_q <= 1'b0;
                tx_q     <= 1'b0;
                rx_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (tslot_p && regi_InquiryEnable) begin
                            state_q  <= S_TX;
                            slot_q   <= '0;
                            rep_q    <= '0;
                            tout_q   <= '0;
                            resp_q   <= '0;
                            train_q  <= 1'b0;
                            koff_q   <= KOFF_A;
                            active_q <= 1'b1;
                            tx_q     <= 1'b1;
                            rx_q     <= 1'b0;
                        end
                    end
                    S_TX, S_RX: begin
                        resp_q <= resp_d;
                        tout_q <= tout_d;
                        if (hit_resp || hit_tout) begin
                            // Response limit wins when both land on the same clock.
                            state_q  <= S_DONE;
                            active_q <= 1'b0;
                            tx_q     <= 1'b0;
                            rx_q     <= 1'b0;
                            done_q   <= hit_resp;
                            tmo_q    <= !hit_resp;
                        end else if (tslot_p) begin
                            state_q <= (state_q == S_TX) ? S_RX : S_TX;
                            tx_q    <= (state_q == S_RX);
                            rx_q    <= (state_q == S_TX);
                            if (wrap) begin
                                slot_q <= '0;
                                if (rep_q >= rep_lim) begin
                                    rep_q   <= '0;
                                    train_q <= ~train_q;
                                    koff_q  <= train_q ? KOFF_A : KOFF_B;
                                end else begin
                                    rep_q <= rep_q + CNT_W'(1);
                                end
                            end else begin
                                slot_q <= slot_q + CNT_W'(1);
                            end
                        end
                    end
                    S_DONE:  state_q <= S_DONE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign iq_active   = active_q;
    assign iq_tx_slot  = tx_q;
    assign iq_rx_slot  = rx_q;
    assign iq_train    = train_q;
    assign iq_koffset  = koff_q;
    assign iq_resp_cnt = resp_q;
    assign iq_done     = done_q;
    assign iq_timeout  = tmo_q;

endmodule

// File: tb/tb_iq_ctrl.sv
// Bench for iq_ctrl: slot-level behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_iq_ctrl;
    localparam int TS = 16;
    localparam int CW = 16;

    logic          clk_6M = 1'b0;
    logic          rst = 1'b0;
    logic          tslot_p = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] tinq = '0;
    logic [9:0]    ntrain = '0;
    logic [7:0]    nresp = '0;
    logic [2:0]    tsco = '0;
    logic [1:0]    scol = '0;
    logic          fhs = 1'b0;

    logic       iq_active, iq_tx_slot, iq_rx_slot, iq_train, iq_done, iq_timeout;
    logic [4:0] iq_koffset;
    logic [7:0] iq_resp_cnt;

    iq_ctrl #(.TRAIN_SLOTS(TS), .CNT_W(CW)) dut (
        .clk_6M(clk_6M), .rst(rst), .tslot_p(tslot_p),
        .regi_InquiryEnable(en), .regi_Tinquirylength(tinq),
        .regi_Ntrain(ntrain), .regi_Nresp(nresp), .regi_Tsco(tsco),
        .regi_scolink_num(scol), .fhs_rcvd(fhs),
        .iq_active(iq_active), .iq_tx_slot(iq_tx_slot), .iq_rx_slot(iq_rx_slot),
        .iq_train(iq_train), .iq_koffset(iq_koffset), .iq_resp_cnt(iq_resp_cnt),
        .iq_done(iq_done), .iq_timeout(iq_timeout)
    );

    always #5 clk_6M = ~clk_6M;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_tout  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: an inquiry is a run of numbered slots; even slots transmit, odd
    // slots listen, and each train lasts TS*Ntrain_eff slots.
    typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
    mst_t m_st = M_IDLE;
    int   m_slot = 0;
    int   m_resp = 0;
    bit   m_train = 1'b0, m_done = 1'b0, m_tout = 1'b0;

    function automatic int neff();
        int b = (ntrain == 0) ? 1 : int'(ntrain);
`ifdef IQ_SCO_TRAIN_EN
        if (tsco == 3'd6) b = b * ((scol == 0) ? 1 : (scol == 1) ? 2 : 3);
`endif
        return b;
    endfunction

    always @(posedge clk_6M) begin
        if (rst) begin
            m_st = M_IDLE; m_slot = 0; m_resp = 0; m_train = 0; m_done = 0; m_tout = 0;
        end else begin
            m_done = 0;
            m_tout = 0;
            case (m_st)
                M_IDLE: if (tslot_p && en) begin
                    m_st = M_RUN; m_slot = 0; m_resp = 0; m_train = 0;
                end
                M_RUN: if (!en) begin
                    m_st = M_IDLE; m_resp = 0; m_train = 0;
                end else begin
                    if (fhs && (m_slot % 2 == 1) && m_resp < 255) m_resp++;
                    if (tslot_p) m_slot++;
                    if (nresp != 0 && m_resp >= int'(nresp)) begin
                        m_st = M_DONE; m_done = 1;
                    end else if (m_slot >= ((tinq == 0) ? 1 : int'(tinq))) begin
                        m_st = M_DONE; m_tout = 1;
                    end else begin
                        m_train = ((m_slot / (TS * neff())) % 2) == 1;
                    end
                end
                M_DONE: if (!en) begin
                    m_st = M_IDLE; m_resp = 0; m_train = 0;
                end
                default: m_st = M_IDLE;
            endcase
        end
    end

    always @(negedge clk_6M) begin
        if (iq_done)    n_done++;
        if (iq_timeout) n_tout++;
        if (!rst) begin
            chk("active",  iq_active,   32'(m_st == M_RUN));
            chk("tx_slot", iq_tx_slot,  32'(m_st == M_RUN && m_slot % 2 == 0));
            chk("rx_slot", iq_rx_slot,  32'(m_st == M_RUN && m_slot % 2 == 1));
            chk("train",   iq_train,    32'(m_train));
            chk("koffset", iq_koffset,  m_train ? 32'd8 : 32'd24);
            chk("resp",    iq_resp_cnt, 32'(m_resp));
            chk("done",    iq_done,     32'(m_done));
            chk("timeout", iq_timeout,  32'(m_tout));
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk_6M); #1; end
    endtask

    task automatic tick();
        tslot_p = 1'b1; step(1); tslot_p = 1'b0; step(3);
    endtask

    task automatic fhs_pulse();
        fhs = 1'b1; step(1); fhs = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sw;
        #1 rst = 1'b1;
        step(3);
        chk("rst_active", iq_active, 0);
        chk("rst_koff", iq_koffset, 24);
        chk("rst_resp", iq_resp_cnt, 0);
        chk("rst_train", iq_train, 0);
        rst = 1'b0;
        step(2);

        // Train A/B alternation with Ntrain=2
        en = 1; ntrain = 2; tinq = 100; nresp = 0;
        step(1);
        chk("t1_idle_tx", iq_tx_slot, 0);
        tslot_p = 1; step(1); tslot_p = 0;
        chk("t1_first_tx", iq_tx_slot, 1);
        chk("t1_first_active", iq_active, 1);
        step(3);
        tick();
        chk("t1_rx", iq_rx_slot, 1);
        chk("t1_rx_tx", iq_tx_slot, 0);
        repeat (30) tick();
        chk("t1_slot31_train", iq_train, 0);
        tick();
        chk("t1_slot32_train", iq_train, 1);
        chk("t1_slot32_koff", iq_koffset, 8);
        chk("t1_slot32_tx", iq_tx_slot, 1);
        repeat (31) tick();
        chk("t1_slot63_train", iq_train, 1);
        tick();
        chk("t1_slot64_train", iq_train, 0);
        chk("t1_slot64_koff", iq_koffset, 24);
        en = 0; step(1);
        chk("t1_abort_active", iq_active, 0);
        step(2);

        // Inquiry timeout after 10 slots
        n_done = 0; n_tout = 0;
        en = 1; tinq = 10; nresp = 0;
        tick();
        repeat (9) tick();
        chk("t2_slot9_active", iq_active, 1);
        tslot_p = 1; step(1); tslot_p = 0;
        chk("t2_tout_pulse", iq_timeout, 1);
        chk("t2_tout_active", iq_active, 0);
        step(3);
        chk("t2_tout_count", n_tout, 1);
        chk("t2_done_count", n_done, 0);
        chk("t2_done_inactive", iq_active, 0);
        en = 0; step(2);

        // Response limit of 3, plus an ignored response during TX
        n_done = 0; n_tout = 0;
        en = 1; tinq = 100; nresp = 3;
        tick();
        fhs_pulse();
        chk("t3_tx_ignored", iq_resp_cnt, 0);
        tick(); fhs_pulse();
        chk("t3_resp1", iq_resp_cnt, 1);
        tick(); tick(); fhs_pulse();
        chk("t3_resp2", iq_resp_cnt, 2);
        tick(); tick(); fhs_pulse();
        chk("t3_done_pulse", iq_done, 1);
        chk("t3_resp3", iq_resp_cnt, 3);
        step(3);
        chk("t3_done_count", n_done, 1);
        chk("t3_tout_count", n_tout, 0);
        chk("t3_resp_hold", iq_resp_cnt, 3);
        en = 0; step(2);

        // Timeout and response limit on the same clock
        n_done = 0; n_tout = 0;
        en = 1; tinq = 2; nresp = 1;
        tick(); tick();
        tslot_p = 1; fhs = 1; step(1); tslot_p = 0; fhs = 0;
        chk("t4_done", iq_done, 1);
        chk("t4_timeout", iq_timeout, 0);
        step(3);
        chk("t4_done_count", n_done, 1);
        chk("t4_tout_count", n_tout, 0);
        en = 0; step(2);

        // Abort mid-RX, restart, then response counter saturation
        n_done = 0; n_tout = 0;
        en = 1; tinq = 100; nresp = 0; ntrain = 2;
        tick(); tick(); fhs_pulse();
        chk("t5_resp_before", iq_resp_cnt, 1);
        en = 0; step(1);
        chk("t5_abort_active", iq_active, 0);
        chk("t5_abort_resp", iq_resp_cnt, 0);
        step(2);
        chk("t5_no_pulses", n_done + n_tout, 0);
        en = 1;
        tslot_p = 1; step(1); tslot_p = 0;
        chk("t5_restart_tx", iq_tx_slot, 1);
        chk("t5_restart_train", iq_train, 0);
        chk("t5_restart_resp", iq_resp_cnt, 0);
        step(3);
        tick();
        fhs = 1; step(300); fhs = 0;
        chk("t5_sat_resp", iq_resp_cnt, 255);
        chk("t5_sat_active", iq_active, 1);
        en = 0; step(2);

        // Ntrain=1 with an HV3-like SCO setting
        en = 1; ntrain = 1; tinq = 100; nresp = 0; tsco = 6; scol = 2;
`ifdef IQ_SCO_TRAIN_EN
        sw = 48;
`else
        sw = 16;
`endif
        tick();
        repeat (sw - 1) tick();
        chk("t6_pre_switch", iq_train, 0);
        tick();
        chk("t6_switch", iq_train, 1);
        chk("t6_switch_koff", iq_koffset, 8);
        en = 0; tsco = 0; scol = 0; step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iq_ctrl.md
Name: iq_ctrl

Overview:
Link Controller inquiry substate controller (core5.1 Spec 8.4.2), the initiating side that pairs with the inquiry-scan window controller. It sequences TX/RX slot alternation, A/B train selection with Ntrain repetitions, the inquiry-length timeout and the response-count limit. Its outputs drive the ID-packet transmitter, the FHS receiver and the hop-selection k_offset.

Parameters:
TRAIN_SLOTS, 16, slots per train (8 TX + 8 RX = 10 ms)
CNT_W, 16, width of slot/timeout/train counters

Ports:
clk_6M  in  1  6 MHz system clock
rst  in  1  asynchronous reset, active-high
tslot_p  in  1  one-clk pulse at each 625 us slot boundary
regi_InquiryEnable  in  1  level; 1 = run inquiry, 0 = abort/idle
regi_Tinquirylength  in  CNT_W  inquiry timeout in slots; 0 treated as 1
regi_Ntrain  in  10  train repetitions before A/B switch; 0 treated as 1
regi_Nresp  in  8  responses ending inquiry; 0 = unlimited
regi_Tsco  in  3  SCO interval code (6 = HV3-like)
regi_scolink_num  in  2  active SCO links
fhs_rcvd  in  1  one-clk pulse: valid FHS response received
iq_active  out  1  high in TX or RX state
iq_tx_slot  out  1  high during TX slots
iq_rx_slot  out  1  high during RX slots
iq_train  out  1  0 = train A, 1 = train B
iq_koffset  out  5  24 for train A, 8 for train B
iq_resp_cnt  out  8  responses counted this inquiry
iq_done  out  1  one-clk pulse: response limit reached
iq_timeout  out  1  one-clk pulse: inquiry length expired

Behaviour:
- Reset: state IDLE; all outputs 0 except iq_koffset=24; all counters 0.
- States: IDLE, TX, RX, DONE.
- IDLE -> TX on first tslot_p with regi_InquiryEnable=1; counters cleared; iq_train=A.
- TX <-> RX swap on every tslot_p; first slot after start is TX.
- slot_in_train counts 0..TRAIN_SLOTS-1 on tslot_p and wraps.
- At wrap, train_rep increments. When train_rep = Ntrain_eff-1 at wrap: iq_train toggles and train_rep clears. Switch takes effect from the TX slot that starts the new train.
- Ntrain_eff = max(regi_Ntrain,1) unless modified by the optional feature.
- tout_cnt increments on each tslot_p while in TX/RX. When it reaches max(regi_Tinquirylength,1): go to DONE and pulse iq_timeout for 1 clk.
- fhs_rcvd is counted only in RX state; it is ignored in TX, IDLE and DONE.
- iq_resp_cnt saturates at 255.
- When regi_Nresp != 0 and the count reaches regi_Nresp: go to DONE and pulse iq_done for 1 clk.
- Same clock hits both timeout and response limit: iq_done pulses, iq_timeout does not; DONE entered once.
- DONE: iq_active, iq_tx_slot and iq_rx_slot are 0; iq_resp_cnt holds. Exit to IDLE only when regi_InquiryEnable=0.
- regi_InquiryEnable=0 in TX/RX: next clk goes to IDLE; counters clear; no done/timeout pulse.
- Register changes mid-inquiry take effect at the next compare; they are not latched at start.
- Outputs are registered; latency from tslot_p to slot/state change is 1 clk.

Optional Feature:
Macro IQ_SCO_TRAIN_EN.
- Defined: when regi_Tsco==6, Ntrain_eff = max(regi_Ntrain,1) x2 for 1 SCO link and x3 for 2 or more links; 0 links means x1. A 12-bit multiply result is used.
- Undefined: Ntrain_eff = max(regi_Ntrain,1); regi_Tsco and regi_scolink_num are unused.

Test Plan:
- Reset then enable, Ntrain=2, Tinquirylength=100 -> first TX 1 clk after tslot_p; TX/RX alternate; iq_train flips to B at slot 32 (koffset 8) and back to A at slot 64.
- Tinquirylength=10, Nresp=0, no fhs -> iq_timeout pulses exactly once 1 clk after the 10th tslot_p; then DONE with iq_active=0.
- Nresp=3, fhs_rcvd in 3 RX slots plus 1 in a TX slot -> TX pulse ignored; iq_resp_cnt=3; iq_done pulses; no iq_timeout.
- Response limit and timeout on same clk (Nresp=1, Tinquirylength=2, fhs on 2nd RX boundary clk) -> iq_done=1, iq_timeout=0.
- Drop enable mid-RX, then re-enable -> IDLE next clk, no pulses; restart from TX, train A, iq_resp_cnt=0.
- With IQ_SCO_TRAIN_EN, regi_Tsco=6, scolink_num=2, Ntrain=1 -> train switch at slot 48; without the macro -> switch at slot 16.
